mac_dot_ctrl: RTL and testbench

Sequencing controller that turns the team's multiply–accumulate datapath into a length-programmable dot-product engine. It accepts a job command (vector length), consumes operand pairs over a valid/ready stream, accumulates their products in an internal guard-bit accumulator, and presents the final sum on a valid/ready result port. It sits between a command issuer (CPU/DMA front end) and downstream result consumers. Only one job is in flight at a time.

---
 rtl/mac_dot_ctrl.sv | 152 +++++++++++++++
 tb/tb_mac_dot_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: length-programmable dot-product sequencer around a MAC datapath.
// Build option: define MAC_DOT_SIGNED_EN for two's-complement operands and result.
module mac_dot_ctrl #(
    parameter  int WIDTH = 8,
    parameter  int LEN_W = 8,
    localparam int ACC_W = 2*WIDTH + LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t state_q;
    state_t state_d;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;

    logic             ext_a;
    logic             ext_b;
    logic [2*WIDTH-1:0] op_a;
    logic [2*WIDTH-1:0] op_b;
    logic [2*WIDTH-1:0] prod;
    logic [ACC_W-1:0]   prod_ext;

    logic accept;
    logic kill;
    logic beat;
    logic last;

`ifdef MAC_DOT_SIGNED_EN
    assign ext_a = in_a[WIDTH-1];
    assign ext_b = in_b[WIDTH-1];
`else
    assign ext_a = 1'b0;
    assign ext_b = 1'b0;
`endif

    // Operands widened to the full product width so the low half of the
    // multiply is exact for both signed and unsigned interpretations.
    assign op_a     = {{WIDTH{ext_a}}, in_a};
    assign op_b     = {{WIDTH{ext_b}}, in_b};
    assign prod     = op_a * op_b;
    assign prod_ext = {{LEN_W{ext_a ^ ext_b ? prod[2*WIDTH-1] : prod[2*WIDTH-1] & (ext_a | ext_b)}}, prod};

    assign accept = start_ready & start;
    assign kill   = busy & abort;
    assign beat   = in_ready & in_valid & ~abort;
    assign last   = (cnt_q == len_q - LEN_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (abort || res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            IDLE: start_ready = 1'b1;
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                res_valid = 1'b1;
                busy      = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    assign res_data = res_valid ? acc_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            unique case (1'b1)
                accept: begin
                    len_q <= len;
                    cnt_q <= '0;
                    acc_q <= '0;
                end
                kill: begin
                    cnt_q <= '0;
                    acc_q <= '0;
                end
                beat: begin
                    cnt_q <= cnt_q + LEN_ONE;
                    acc_q <= acc_q + prod_ext;
                end
                default: begin
                    cnt_q <= cnt_q;
                    acc_q <= acc_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb_mac_dot_ctrl: randomized and directed checks of mac_dot_ctrl
// against a sum-of-products reference model.
module tb_mac_dot_ctrl;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;
    localparam int ACC_W = 2*WIDTH + LEN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             start_ready;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             busy;

    int vectors = 0;
    int errors  = 0;

    mac_dot_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .len(len), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference product: mathematical a*b under the configured signedness.
    function automatic logic [ACC_W-1:0] ref_prod(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        longint x;
        logic [63:0] y;
`ifdef MAC_DOT_SIGNED_EN
        x = longint'($signed(a)) * longint'($signed(b));
`else
        x = longint'(a) * longint'(b);
`endif
        y = x;
        return y[ACC_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; in_valid = 0; res_ready = 0;
        len = '0; in_a = '0; in_b = '0;
    endtask

    task automatic start_job(input int n);
        start = 1; len = LEN_W'(n);
        tick();
        start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #1;
        vectors++;
        if ({start_ready, in_ready, res_valid, busy} !== 4'b1000 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got sr=%b ir=%b rv=%b busy=%b data=%0d want 1 0 0 0 0",
                     start_ready, in_ready, res_valid, busy, res_data);
        end
        tick();
        rst = 0;
        tick();
        vectors++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got sr=%b busy=%b want 1 0", start_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic [ACC_W-1:0] exp = '0;
        start_job(4);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_run got ir=%b busy=%b sr=%b want 1 1 0", in_ready, busy, start_ready);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_a = WIDTH'(2*i+1); in_b = WIDTH'(2*i+2);
            exp += ref_prod(in_a, in_b);
            vectors++;
            if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d got ir=%b rv=%b want 1 0", i, in_ready, res_valid);
            end
            tick();
        end
        in_valid = 0;
        vectors++;
        if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== exp || exp !== ACC_W'(100)) begin
            errors++;
            $display("FAIL basic_result got rv=%b ir=%b data=%0d want 1 0 %0d", res_valid, in_ready, res_data, exp);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        vectors++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept got rv=%b sr=%b busy=%b want 0 1 0", res_valid, start_ready, busy);
        end
    endtask

    task automatic test_throttle();
        logic [ACC_W-1:0] exp = '0;
        logic [4:0] pat = 5'b10101;
        start_job(3);
        for (int i = 4; i >= 0; i--) begin
            in_valid = pat[i]; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
            if (pat[i]) exp += ref_prod(in_a, in_b);
            tick();
        end
        in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (res_valid !== 1'b1 || res_data !== exp) begin
                errors++;
                $display("FAIL throttle_hold%0d got rv=%b data=%0d want 1 %0d", i, res_valid, res_data, exp);
            end
            tick();
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        tick();
        vectors++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL throttle_single got rv=%b sr=%b want 0 1", res_valid, start_ready);
        end
    endtask

    task automatic test_max_len();
        logic [ACC_W-1:0] exp = '0;
        start_job(255);
        in_valid = 1; in_a = 8'hFF; in_b = 8'hFF;
        for (int i = 0; i < 255; i++) begin
            exp += ref_prod(in_a, in_b);
            tick();
        end
        in_valid = 0;
`ifndef MAC_DOT_SIGNED_EN
        vectors++;
        if (exp !== ACC_W'(16581375) || res_data !== exp) begin
            errors++;
            $display("FAIL maxlen_value got %0d want 16581375", res_data);
        end
`endif
        vectors++;
        if (res_valid !== 1'b1 || res_data !== exp) begin
            errors++;
            $display("FAIL maxlen_result got rv=%b data=%0d want 1 %0d", res_valid, res_data, exp);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask

    task automatic test_zero_len();
        logic [ACC_W-1:0] exp = '0;
        start_job(0);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_result got rv=%b ir=%b data=%0d want 1 0 0", res_valid, in_ready, res_data);
        end
        start = 1; len = 8'd5;
        tick();
        start = 0;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== '0) begin
            errors++;
            $display("FAIL zero_start_ignored got rv=%b data=%0d want 1 0", res_valid, res_data);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        start_job(2);
        in_valid = 1; in_a = 8'd10; in_b = 8'd3;
        start = 1; len = 8'd7;
        exp += ref_prod(in_a, in_b);
        tick();
        start = 0;
        in_a = 8'd4; in_b = 8'd6;
        exp += ref_prod(in_a, in_b);
        tick();
        in_valid = 0;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== exp) begin
            errors++;
            $display("FAIL run_start_ignored got rv=%b data=%0d want 1 %0d", res_valid, res_data, exp);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask

    task automatic test_abort();
        start_job(5);
        in_valid = 1; in_a = 8'd7; in_b = 8'd7;
        tick(); tick();
        abort = 1;
        tick();
        abort = 0; in_valid = 0;
        vectors++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_run got sr=%b busy=%b rv=%b want 1 0 0", start_ready, busy, res_valid);
        end
        start_job(1);
        in_valid = 1; in_a = 8'd9; in_b = 8'd9;
        tick();
        in_valid = 0;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== ref_prod(8'd9, 8'd9)) begin
            errors++;
            $display("FAIL abort_next got rv=%b data=%0d want 1 81", res_valid, res_data);
        end
        abort = 1; res_ready = 1;
        tick();
        abort = 0; res_ready = 0;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_done got rv=%b busy=%b want 0 0", res_valid, busy);
        end
        start = 1; abort = 1; len = 8'd1;
        tick();
        start = 0; abort = 0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_over_abort got ir=%b busy=%b want 1 1", in_ready, busy);
        end
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            logic [ACC_W-1:0] exp = '0;
            int n = $urandom_range(0, 12);
            int got = 0;
            int cut = ($urandom_range(0, 4) == 0 && n > 0) ? $urandom_range(0, n-1) : -1;
            bit killed = 0;
            start_job(n);
            while (got < n) begin
                in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
                in_valid = ($urandom_range(0, 2) != 0);
                if (got == cut) begin
                    abort = 1; in_valid = 1;
                    tick();
                    abort = 0; killed = 1;
                    break;
                end
                vectors++;
                if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand%0d_beat got ir=%b rv=%b want 1 0", j, in_ready, res_valid);
                end
                if (in_valid) begin
                    exp += ref_prod(in_a, in_b);
                    got++;
                end
                tick();
            end
            in_valid = 0;
            if (killed) begin
                vectors++;
                if (busy !== 1'b0 || res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand%0d_abort got busy=%b rv=%b want 0 0", j, busy, res_valid);
                end
            end else begin
                repeat ($urandom_range(0, 3)) tick();
                vectors++;
                if (res_valid !== 1'b1 || res_data !== exp) begin
                    errors++;
                    $display("FAIL rand%0d_result got rv=%b data=%0d want 1 %0d", j, res_valid, res_data, exp);
                end
                res_ready = 1;
                tick();
                res_ready = 0;
            end
        end
    endtask

`ifdef MAC_DOT_SIGNED_EN
    task automatic test_signed();
        logic [ACC_W-1:0] want = -ACC_W'(22);
        start_job(2);
        in_valid = 1; in_a = -8'sd3; in_b = 8'sd4;
        tick();
        in_a = 8'sd2; in_b = -8'sd5;
        tick();
        in_valid = 0;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== want) begin
            errors++;
            $display("FAIL signed_result got rv=%b data=%0h want 1 %0h", res_valid, res_data, want);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask
`endif

    task automatic test_async_reset();
        start_job(4);
        in_valid = 1; in_a = 8'd5; in_b = 8'd5;
        tick(); tick();
        #2;
        rst = 1;
        #1;
        vectors++;
        if ({start_ready, in_ready, res_valid, busy} !== 4'b1000 || res_data !== '0) begin
            errors++;
            $display("FAIL async_reset got sr=%b ir=%b rv=%b busy=%b want 1 0 0 0",
                     start_ready, in_ready, res_valid, busy);
        end
        in_valid = 0;
        tick();
        #2;
        rst = 0;
        tick();
        start_job(0);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== '0) begin
            errors++;
            $display("FAIL after_reset got rv=%b data=%0d want 1 0", res_valid, res_data);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_throttle();
        test_max_len();
        test_zero_len();
        test_abort();
        test_random();
`ifdef MAC_DOT_SIGNED_EN
        test_signed();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
